// File: rtl/uart_rx.sv
// UART receiver: 8N1-style frames (DATA_BITS data bits, one stop bit) sampled
// with OVERSAMPLE ticks per bit, all derived from the system clock.
module uart_rx #(
  parameter int SYSTEM_CLK_FREQ = 125_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int OVERSAMPLE      = 16,
  parameter int DATA_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CLKS_PER_TICK = SYSTEM_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_W        = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int SAMP_W        = $clog2(OVERSAMPLE);
  localparam int BIT_W         = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_TICK - 1);
  localparam logic [SAMP_W-1:0] HALF_LAST = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] FULL_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [SAMP_W-1:0]    samp_cnt_q, samp_cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 tick;

  // Two-flop synchroniser bringing the asynchronous rx pin into the clk domain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // two synchroniser stages into one.
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // The prescaler wraps once per oversample tick.
  assign tick = (tick_cnt_q == TICK_LAST);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state logic: start qualification, data shifting and stop-bit check.
  always_comb begin
    // NOTE: every signal written below gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    samp_cnt_d = samp_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Hold the prescaler at zero so the first tick lands a fixed
        // distance from the detected start edge.
        tick_cnt_d = '0;
        samp_cnt_d = '0;
        bit_idx_d  = '0;
        if (!rx_s_q) state_d = S_START;
      end

      S_START: begin
        if (tick) begin
          if (samp_cnt_q == HALF_LAST) begin
            samp_cnt_d = '0;
            // A line that is high again at mid-bit was only a glitch.
            state_d    = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            samp_cnt_d = samp_cnt_q + SAMP_W'(1);
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (samp_cnt_q == FULL_LAST) begin
            samp_cnt_d = '0;
            shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == BIT_LAST) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + BIT_W'(1);
            end
          end else begin
            samp_cnt_d = samp_cnt_q + SAMP_W'(1);
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          if (samp_cnt_q == FULL_LAST) begin
            samp_cnt_d = '0;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT_IDLE;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + SAMP_W'(1);
          end
        end
      end

      S_WAIT_IDLE: begin
        // A stuck-low line must return high before a new start is accepted.
        if (rx_s_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames
// compared against a frame-level reference model.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int BIT      = CLK_FREQ / BAUD; // 160 clocks per bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] dv_vals[$];
  int         dv_cyc[$];
  int         fe_cnt    = 0;
  int         both_cnt  = 0;
  bit         busy_seen = 1'b0;
  int         fall_cyc  = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(
    .SYSTEM_CLK_FREQ(CLK_FREQ),
    .BAUD_RATE      (BAUD),
    .OVERSAMPLE     (OS),
    .DATA_BITS      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_vals.push_back(data_out);
      dv_cyc.push_back(cyc);
    end
    if (frame_error === 1'b1) fe_cnt++;
    if (data_valid === 1'b1 && frame_error === 1'b1) both_cnt++;
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  // Reference model: decode a 10-bit line image (bit 0 = start, bits 1..8 =
  // data LSB first, bit 9 = stop). Returns {good_frame, byte}.
  function automatic logic [8:0] model_rx(input logic [9:0] line);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = line[i+1];
    return {(line[9] == 1'b1) && (line[0] == 1'b0), v};
  endfunction

  // Drives one frame; called and returning just after a falling edge.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] line;
    line     = {stop, d, 1'b0};
    fall_cyc = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      rx = line[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for_dv(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dv_vals.size() >= n) break;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_mon();
    dv_vals.delete();
    dv_cyc.delete();
    fe_cnt    = 0;
    busy_seen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h, expected 00", data_out); end
    n_checks++;
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b, expected 0", data_valid); end
    n_checks++;
    if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error: got %b, expected 0", frame_error); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_single();
    logic [8:0] m;
    int         lat;
    clear_mon();
    m = model_rx({1'b1, 8'hA5, 1'b0});
    send_frame(8'hA5, 1'b1);
    wait_for_dv(1, 4 * BIT);
    idle(20);
    last_good = m[7:0];
    n_checks++;
    if (dv_vals.size() != 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d, expected 1", dv_vals.size()); end
    n_checks++;
    if (data_out !== m[7:0]) begin n_fail++; $display("FAIL single_data_out: got %h, expected %h", data_out, m[7:0]); end
    if (dv_cyc.size() > 0) begin
      lat = dv_cyc[0] - fall_cyc;
      n_checks++;
      if (lat < 10 * BIT - 3 * OS / OS - 2 || lat > 10 * BIT - 80 + 3) begin end
      if (lat < 1517 || lat > 1523) begin n_fail++; $display("FAIL single_latency: got %0d clks, expected 1520 +/-3", lat); end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b, expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_for_dv(2, 4 * BIT);
    idle(20);
    last_good = 8'hFF;
    n_checks++;
    if (dv_vals.size() != 2) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d, expected 2", dv_vals.size()); end
    if (dv_vals.size() == 2) begin
      n_checks++;
      if (dv_vals[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h, expected 00", dv_vals[0]); end
      n_checks++;
      if (dv_vals[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h, expected ff", dv_vals[1]); end
      n_checks++;
      if ((dv_cyc[1] - dv_cyc[0]) < 10 * BIT - 1 || (dv_cyc[1] - dv_cyc[0]) > 10 * BIT + 1) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d clks, expected 1600 +/-1", dv_cyc[1] - dv_cyc[0]);
      end
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(2 * BIT);
    n_checks++;
    if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_pulse: got %b, expected 1", busy_seen); end
    n_checks++;
    if (dv_vals.size() != 0) begin n_fail++; $display("FAIL glitch_no_valid: got %0d pulses, expected 0", dv_vals.size()); end
    n_checks++;
    if (fe_cnt != 0) begin n_fail++; $display("FAIL glitch_no_ferr: got %0d pulses, expected 0", fe_cnt); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_idle: got %b, expected 0", busy); end
    send_frame(8'h3C, 1'b1);
    wait_for_dv(1, 4 * BIT);
    idle(20);
    last_good = 8'h3C;
    n_checks++;
    if (dv_vals.size() != 1 || data_out !== 8'h3C) begin
      n_fail++; $display("FAIL glitch_next_frame: got %0d pulses data %h, expected 1 pulse data 3c", dv_vals.size(), data_out);
    end
  endtask

  task automatic test_framing_error();
    clear_mon();
    send_frame(8'h55, 1'b0);
    repeat (500) @(negedge clk);
    n_checks++;
    if (fe_cnt != 1) begin n_fail++; $display("FAIL ferr_pulse_count: got %0d, expected 1", fe_cnt); end
    n_checks++;
    if (dv_vals.size() != 0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d pulses, expected 0", dv_vals.size()); end
    n_checks++;
    if (data_out !== last_good) begin n_fail++; $display("FAIL ferr_data_kept: got %h, expected %h", data_out, last_good); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_held: got %b, expected 1", busy); end
    idle(5);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: got %b, expected 0", busy); end
    send_frame(8'h12, 1'b1);
    wait_for_dv(1, 4 * BIT);
    idle(20);
    last_good = 8'h12;
    n_checks++;
    if (dv_vals.size() != 1 || data_out !== 8'h12) begin
      n_fail++; $display("FAIL ferr_next_frame: got %0d pulses data %h, expected 1 pulse data 12", dv_vals.size(), data_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] line;
    clear_mon();
    line = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = line[i];
      repeat (BIT) @(negedge clk);
    end
    rx = line[5];                    // data bit 4
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    last_good = 8'h00;
    n_checks++;
    if (data_out !== 8'h00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state: got data %h busy %b, expected data 00 busy 0", data_out, busy);
    end
    idle(200);
    send_frame(8'h7E, 1'b1);
    wait_for_dv(1, 4 * BIT);
    idle(20);
    last_good = 8'h7E;
    n_checks++;
    if (dv_vals.size() != 1) begin n_fail++; $display("FAIL midrst_pulse_count: got %0d, expected 1", dv_vals.size()); end
    n_checks++;
    if (data_out !== 8'h7E) begin n_fail++; $display("FAIL midrst_data_out: got %h, expected 7e", data_out); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_fe;
    logic [7:0] d;
    logic       s;
    logic [8:0] m;
    clear_mon();
    exp_fe = 0;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      m = model_rx({s, d, 1'b0});
      send_frame(d, s);
      if (m[8]) begin
        exp_q.push_back(m[7:0]);
        last_good = m[7:0];
        idle($urandom_range(0, 200));
      end else begin
        exp_fe++;
        idle(20 + $urandom_range(0, 100));
      end
    end
    idle(2 * BIT);
    n_checks++;
    if (dv_vals.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_pulse_count: got %0d, expected %0d", dv_vals.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (dv_vals[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte_%0d: got %h, expected %h", i, dv_vals[i], exp_q[i]); end
      end
    end
    n_checks++;
    if (fe_cnt != exp_fe) begin n_fail++; $display("FAIL rand_ferr_count: got %0d, expected %0d", fe_cnt, exp_fe); end
    n_checks++;
    if (data_out !== last_good) begin n_fail++; $display("FAIL rand_data_out: got %h, expected %h", data_out, last_good); end
    n_checks++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL valid_and_ferr_overlap: got %0d cycles, expected 0", both_cnt); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    idle(50);
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(90_000 * 10);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

endmodule
